// File: rtl/ctrl_fsm_if.sv
// ---------------------------------------------------------------------------
// ctrl_fsm_if -- instruction/data memory handshake bundle for ctrl_fsm.
//
// Signals (named from the controller's point of view):
//   imem_req_o    controller -> imem   fetch request
//   imem_ready_i  imem -> controller   fetch data valid this cycle
//   dmem_req_o    controller -> dmem   data access request
//   dmem_we_o     controller -> dmem   1 = store, 0 = load
//   dmem_size_o   controller -> dmem   access size (funct3[1:0])
//   dmem_ready_i  dmem -> controller   access completes this cycle
//
// Modports: master = controller side, slave = memory side.
// ---------------------------------------------------------------------------
interface ctrl_fsm_if;
    logic       imem_req_o;
    logic       imem_ready_i;
    logic       dmem_req_o;
    logic       dmem_we_o;
    logic [1:0] dmem_size_o;
    logic       dmem_ready_i;

    modport master (
        output imem_req_o, dmem_req_o, dmem_we_o, dmem_size_o,
        input  imem_ready_i, dmem_ready_i
    );

    modport slave (
        input  imem_req_o, dmem_req_o, dmem_we_o, dmem_size_o,
        output imem_ready_i, dmem_ready_i
    );
endinterface

// File: rtl/ctrl_fsm.sv
// ---------------------------------------------------------------------------
// ctrl_fsm -- multi-cycle RV32I control FSM.
//
// States FETCH(0) DECODE(1) EXECUTE(2) MEM(3) WB(4) FAULT(5). The opcode and
// funct3 are captured once in DECODE; every later state works from the
// captured class so the decoder inputs may change freely afterwards.
// A wait counter bounds each memory handshake; running out of patience
// parks the controller in FAULT until reset.
//
// Parameter: MAX_WAIT (2..255) -- wait cycles tolerated before faulting.
// Build option: CTRL_FSM_ILLEGAL_TRAP_EN -- when defined, an illegal opcode
//   in DECODE goes to FAULT; otherwise it executes as a NOP.
//
// Ports:
//   clk_i, rst_n_i            clock, synchronous active-low reset
//   opcode_i, funct3_i        from instruction decoder
//   branch_cond_i             branch comparator result
//   bus                       imem/dmem handshake (ctrl_fsm_if.master)
//   ir_we_o, pc_we_o, rf_we_o write enables
//   alu_a_sel_o, alu_b_sel_o  ALU operand selects (a: 0=rs1 1=pc, b: 0=rs2 1=imm)
//   pc_sel_o, wb_sel_o        next-pc / writeback selects
//   imm_sel_o                 immediate format (0=I 1=S 2=B 3=U 4=J)
//   state_o, fault_o, retire_o
// ---------------------------------------------------------------------------
module ctrl_fsm #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [6:0]       opcode_i,
    input  logic [2:0]       funct3_i,
    input  logic             branch_cond_i,
    ctrl_fsm_if.master       bus,
    output logic             ir_we_o,
    output logic             pc_we_o,
    output logic             rf_we_o,
    output logic             alu_a_sel_o,
    output logic             alu_b_sel_o,
    output logic [1:0]       pc_sel_o,
    output logic [1:0]       wb_sel_o,
    output logic [2:0]       imm_sel_o,
    output logic [2:0]       state_o,
    output logic             fault_o,
    output logic             retire_o
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_FAULT   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        C_NOP, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH,
        C_LOAD, C_STORE, C_OPIMM, C_OP
    } cls_e;

    localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

    state_e     r_state, w_nxt;
    cls_e       r_cls, w_dec_cls;
    logic [2:0] r_f3;
    logic [7:0] r_wait, w_wait_nxt;
    logic       w_wait_inc, w_dec_legal;

    // funct3[2] (load sign) and, without the trap option, the legality flag
    // have no consumer in the controller.
    logic [1:0] w_unused;
    assign w_unused   = {r_f3[2], w_dec_legal};
    assign w_wait_nxt = r_wait + 8'd1;

    // Opcode -> class for the DECODE capture.
    always_comb begin
        w_dec_cls   = C_NOP;
        w_dec_legal = 1'b1;
        case (opcode_i)
            7'b0110111: w_dec_cls = C_LUI;
            7'b0010111: w_dec_cls = C_AUIPC;
            7'b1101111: w_dec_cls = C_JAL;
            7'b1100111: w_dec_cls = C_JALR;
            7'b1100011: w_dec_cls = C_BRANCH;
            7'b0000011: w_dec_cls = C_LOAD;
            7'b0100011: w_dec_cls = C_STORE;
            7'b0010011: w_dec_cls = C_OPIMM;
            7'b0110011: w_dec_cls = C_OP;
            7'b0001111, 7'b1110011: w_dec_cls = C_NOP;
            default:    w_dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= S_FETCH;
            r_wait  <= '0;
            r_cls   <= C_NOP;
            r_f3    <= '0;
        end else begin
            r_state <= w_nxt;
            // Counter restarts whenever a new handshake phase begins.
            if (w_nxt != r_state && (w_nxt == S_FETCH || w_nxt == S_MEM))
                r_wait <= '0;
            else if (w_wait_inc)
                r_wait <= w_wait_nxt;
            if (r_state == S_DECODE) begin
                r_cls <= w_dec_cls;
                r_f3  <= funct3_i;
            end
        end
    end

    always_comb begin
        w_nxt           = r_state;
        w_wait_inc      = 1'b0;
        bus.imem_req_o  = 1'b0;
        bus.dmem_req_o  = 1'b0;
        bus.dmem_we_o   = 1'b0;
        bus.dmem_size_o = 2'd0;
        ir_we_o         = 1'b0;
        pc_we_o         = 1'b0;
        rf_we_o         = 1'b0;
        alu_a_sel_o     = 1'b0;
        alu_b_sel_o     = 1'b0;
        pc_sel_o        = 2'd0;
        wb_sel_o        = 2'd0;
        imm_sel_o       = 3'd0;
        fault_o         = 1'b0;
        retire_o        = 1'b0;
        state_o         = r_state;

        case (r_state)
            S_FETCH: begin
                bus.imem_req_o = 1'b1;
                if (bus.imem_ready_i) begin
                    ir_we_o = 1'b1;
                    w_nxt   = S_DECODE;
                end else begin
                    w_wait_inc = 1'b1;
                    // Fault on the cycle the counter would reach the limit.
                    if (w_wait_nxt == LP_MAX_WAIT) w_nxt = S_FAULT;
                end
            end
            S_DECODE: begin
`ifdef CTRL_FSM_ILLEGAL_TRAP_EN
                w_nxt = w_dec_legal ? S_EXECUTE : S_FAULT;
`else
                w_nxt = S_EXECUTE;
`endif
            end
            S_EXECUTE: begin
                alu_a_sel_o = (r_cls == C_AUIPC || r_cls == C_JAL || r_cls == C_BRANCH);
                alu_b_sel_o = (r_cls != C_OP);
                case (r_cls)
                    C_STORE:        imm_sel_o = 3'd1;
                    C_BRANCH:       imm_sel_o = 3'd2;
                    C_LUI, C_AUIPC: imm_sel_o = 3'd3;
                    C_JAL:          imm_sel_o = 3'd4;
                    default:        imm_sel_o = 3'd0;
                endcase
                if (r_cls == C_BRANCH) begin
                    pc_we_o  = 1'b1;
                    retire_o = 1'b1;
                    pc_sel_o = branch_cond_i ? 2'd1 : 2'd0;
                    w_nxt    = S_FETCH;
                end else if (r_cls == C_LOAD || r_cls == C_STORE) begin
                    w_nxt = S_MEM;
                end else begin
                    w_nxt = S_WB;
                end
            end
            S_MEM: begin
                bus.dmem_req_o  = 1'b1;
                bus.dmem_we_o   = (r_cls == C_STORE);
                bus.dmem_size_o = r_f3[1:0];
                if (bus.dmem_ready_i) begin
                    if (r_cls == C_STORE) begin
                        pc_we_o  = 1'b1;
                        retire_o = 1'b1;
                        w_nxt    = S_FETCH;
                    end else begin
                        w_nxt = S_WB;
                    end
                end else begin
                    w_wait_inc = 1'b1;
                    if (w_wait_nxt == LP_MAX_WAIT) w_nxt = S_FAULT;
                end
            end
            S_WB: begin
                rf_we_o  = (r_cls != C_NOP);
                pc_we_o  = 1'b1;
                retire_o = 1'b1;
                case (r_cls)
                    C_LOAD:        wb_sel_o = 2'd1;
                    C_JAL, C_JALR: wb_sel_o = 2'd2;
                    C_LUI:         wb_sel_o = 2'd3;
                    default:       wb_sel_o = 2'd0;
                endcase
                case (r_cls)
                    C_JAL:   pc_sel_o = 2'd1;
                    C_JALR:  pc_sel_o = 2'd2;
                    default: pc_sel_o = 2'd0;
                endcase
                w_nxt = S_FETCH;
            end
            S_FAULT: begin
                fault_o = 1'b1;
            end
            default: begin
                w_nxt = S_FETCH;
            end
        endcase

        // Reset silences every output in the same cycle, so an abandoned
        // transaction never leaks a write or retire pulse.
        if (!rst_n_i) begin
            bus.imem_req_o  = 1'b0;
            bus.dmem_req_o  = 1'b0;
            bus.dmem_we_o   = 1'b0;
            bus.dmem_size_o = 2'd0;
            ir_we_o         = 1'b0;
            pc_we_o         = 1'b0;
            rf_we_o         = 1'b0;
            alu_a_sel_o     = 1'b0;
            alu_b_sel_o     = 1'b0;
            pc_sel_o        = 2'd0;
            wb_sel_o        = 2'd0;
            imm_sel_o       = 3'd0;
            fault_o         = 1'b0;
            retire_o        = 1'b0;
            state_o         = 3'd0;
        end
    end

endmodule

// File: tb/tb_ctrl_fsm.sv
module tb_ctrl_fsm;

    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                           OP_JAL = 7'b1101111, OP_JALR  = 7'b1100111,
                           OP_BR  = 7'b1100011, OP_LOAD  = 7'b0000011,
                           OP_ST  = 7'b0100011, OP_IMM   = 7'b0010011,
                           OP_REG = 7'b0110011, OP_FENCE = 7'b0001111,
                           OP_BAD = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       bcond;
    logic       ir_we, pc_we, rf_we, alu_a, alu_b, fault, retire;
    logic [1:0] pc_sel, wb_sel;
    logic [2:0] imm_sel, state;

    int checks = 0;
    int errors = 0;

    ctrl_fsm_if bus();

    ctrl_fsm #(.MAX_WAIT(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .opcode_i(opcode), .funct3_i(funct3),
        .branch_cond_i(bcond), .bus(bus.master), .ir_we_o(ir_we), .pc_we_o(pc_we),
        .rf_we_o(rf_we), .alu_a_sel_o(alu_a), .alu_b_sel_o(alu_b),
        .pc_sel_o(pc_sel), .wb_sel_o(wb_sel), .imm_sel_o(imm_sel),
        .state_o(state), .fault_o(fault), .retire_o(retire)
    );

    always #5 clk = ~clk;

    // Observed outputs packed in the same order as ex() below.
    logic [21:0] act;
    assign act = {state, bus.imem_req_o, ir_we, bus.dmem_req_o, bus.dmem_we_o,
                  bus.dmem_size_o, pc_we, rf_we, pc_sel, wb_sel, imm_sel,
                  alu_a, alu_b, retire, fault};

    typedef struct {
        string       name;
        logic        rst;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        bc, ir, dr;
        logic [21:0] exp;
    } vec_t;

    vec_t vq[$];

    function automatic logic [21:0] ex(input int st, imreq, irwe, dreq, dwe, dsz,
                                       pcwe, rfwe, pcs, wbs, imm, aa, ab, ret, flt);
        return {st[2:0], imreq[0], irwe[0], dreq[0], dwe[0], dsz[1:0], pcwe[0],
                rfwe[0], pcs[1:0], wbs[1:0], imm[2:0], aa[0], ab[0], ret[0], flt[0]};
    endfunction

    function automatic logic [21:0] eZ();            return '0; endfunction
    function automatic logic [21:0] eF(input int i); return ex(0,1,i,0,0,0,0,0,0,0,0,0,0,0,0); endfunction
    function automatic logic [21:0] eD();            return ex(1,0,0,0,0,0,0,0,0,0,0,0,0,0,0); endfunction
    function automatic logic [21:0] eE(input int imm, aa, ab, pcwe, pcs, ret);
        return ex(2,0,0,0,0,0,pcwe,0,pcs,0,imm,aa,ab,ret,0);
    endfunction
    function automatic logic [21:0] eM(input int dwe, dsz, pcwe, ret);
        return ex(3,0,0,1,dwe,dsz,pcwe,0,0,0,0,0,0,ret,0);
    endfunction
    function automatic logic [21:0] eW(input int rfwe, wbs, pcs);
        return ex(4,0,0,0,0,0,1,rfwe,pcs,wbs,0,0,0,1,0);
    endfunction
    function automatic logic [21:0] eX();            return ex(5,0,0,0,0,0,0,0,0,0,0,0,0,0,1); endfunction

    task automatic add(input string n, input logic r, input logic [6:0] op,
                       input logic [2:0] f3, input logic bc, ir, dr, input logic [21:0] e);
        vq.push_back('{n, r, op, f3, bc, ir, dr, e});
    endtask

    task automatic chk_vec(input string n, input logic [21:0] a, input logic [21:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %b want %b", n, a, e);
        end
    endtask

    task automatic chk_int(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s got %0d want %0d", n, a, e);
        end
    endtask

    // One cycle: drive after the edge, leave time for settling, then return.
    task automatic step(input logic r, input logic [6:0] op, input logic [2:0] f3,
                        input logic bc, ir, dr);
        @(posedge clk);
        #2;
        rst_n = r; opcode = op; funct3 = f3; bcond = bc;
        bus.imem_ready_i = ir; bus.dmem_ready_i = dr;
        #2;
    endtask

    // Runs one instruction from FETCH with fixed fetch/mem delays, counting
    // cycles up to and including the retire pulse.
    task automatic run_cpi(input string n, input logic [6:0] op, input logic [2:0] f3,
                           input logic bc, input int fw, input int mw,
                           input int exp_cpi, input int exp_rf);
        int  cyc = 0;
        int  rfc = 0;
        bit  done = 0;
        while (!done && cyc < 40) begin
            step(1'b1, op, f3, bc, cyc >= fw, cyc >= fw + 3 + mw);
            if (rf_we) rfc++;
            if (retire) done = 1;
            cyc++;
        end
        chk_int({n, "_cpi"}, done ? cyc : -1, exp_cpi);
        chk_int({n, "_rfwe"}, rfc, exp_rf);
    endtask

    initial begin
        rst_n = 1'b0; opcode = '0; funct3 = '0; bcond = 1'b0;
        bus.imem_ready_i = 1'b0; bus.dmem_ready_i = 1'b0;

        add("reset",      0, OP_IMM, 0, 0, 1, 0, eZ());
        add("addi_f",     1, OP_IMM, 0, 0, 1, 0, eF(1));
        add("addi_d",     1, OP_IMM, 0, 0, 0, 0, eD());
        add("addi_e",     1, OP_IMM, 0, 0, 0, 0, eE(0,0,1,0,0,0));
        add("addi_wb",    1, OP_IMM, 0, 0, 0, 0, eW(1,0,0));
        add("lui_f",      1, OP_LUI, 0, 0, 1, 0, eF(1));
        add("lui_d",      1, OP_LUI, 0, 0, 0, 0, eD());
        add("lui_e_latch",1, OP_REG, 0, 0, 0, 0, eE(3,0,1,0,0,0));
        add("lui_wb",     1, OP_REG, 0, 0, 0, 0, eW(1,3,0));
        add("jal_f_wait", 1, OP_JAL, 0, 0, 0, 0, eF(0));
        add("jal_f",      1, OP_JAL, 0, 0, 1, 0, eF(1));
        add("jal_d",      1, OP_JAL, 0, 0, 0, 0, eD());
        add("jal_e",      1, OP_JAL, 0, 0, 0, 0, eE(4,1,1,0,0,0));
        add("jal_wb",     1, OP_JAL, 0, 0, 0, 0, eW(1,2,1));
        add("jalr_f",     1, OP_JALR,0, 0, 1, 0, eF(1));
        add("jalr_d",     1, OP_JALR,0, 0, 0, 0, eD());
        add("jalr_e",     1, OP_JALR,0, 0, 0, 0, eE(0,0,1,0,0,0));
        add("jalr_wb",    1, OP_JALR,0, 0, 0, 0, eW(1,2,2));
        add("br1_f",      1, OP_BR,  0, 1, 1, 0, eF(1));
        add("br1_d",      1, OP_BR,  0, 1, 0, 0, eD());
        add("br1_e",      1, OP_BR,  0, 1, 0, 0, eE(2,1,1,1,1,1));
        add("br0_f",      1, OP_BR,  0, 0, 1, 0, eF(1));
        add("br0_d",      1, OP_BR,  0, 0, 0, 0, eD());
        add("br0_e",      1, OP_BR,  0, 0, 0, 0, eE(2,1,1,1,0,1));
        add("ld_f",       1, OP_LOAD,2, 0, 1, 0, eF(1));
        add("ld_d",       1, OP_LOAD,2, 0, 0, 0, eD());
        add("ld_e",       1, OP_LOAD,2, 0, 0, 0, eE(0,0,1,0,0,0));
        add("ld_m0",      1, OP_LOAD,2, 0, 0, 0, eM(0,2,0,0));
        add("ld_m1",      1, OP_LOAD,2, 0, 0, 0, eM(0,2,0,0));
        add("ld_m2",      1, OP_LOAD,2, 0, 0, 0, eM(0,2,0,0));
        add("ld_m_limit", 1, OP_LOAD,2, 0, 0, 1, eM(0,2,0,0));
        add("ld_wb",      1, OP_LOAD,2, 0, 0, 0, eW(1,1,0));
        add("st_f",       1, OP_ST,  1, 0, 1, 0, eF(1));
        add("st_d",       1, OP_ST,  1, 0, 0, 0, eD());
        add("st_e",       1, OP_ST,  1, 0, 0, 0, eE(1,0,1,0,0,0));
        add("st_m",       1, OP_ST,  1, 0, 0, 1, eM(1,1,1,1));
        add("auipc_f_w0", 1, OP_AUIPC,0,0, 0, 0, eF(0));
        add("auipc_f_w1", 1, OP_AUIPC,0,0, 0, 0, eF(0));
        add("auipc_f_w2", 1, OP_AUIPC,0,0, 0, 0, eF(0));
        add("auipc_f_lim",1, OP_AUIPC,0,0, 1, 0, eF(1));
        add("auipc_d",    1, OP_AUIPC,0,0, 0, 0, eD());
        add("auipc_e",    1, OP_AUIPC,0,0, 0, 0, eE(3,1,1,0,0,0));
        add("auipc_wb",   1, OP_AUIPC,0,0, 0, 0, eW(1,0,0));
        add("op_f",       1, OP_REG, 0, 0, 1, 0, eF(1));
        add("op_d",       1, OP_REG, 0, 0, 0, 0, eD());
        add("op_e",       1, OP_REG, 0, 0, 0, 0, eE(0,0,0,0,0,0));
        add("op_wb",      1, OP_REG, 0, 0, 0, 0, eW(1,0,0));
        add("fence_f",    1, OP_FENCE,0,0, 1, 0, eF(1));
        add("fence_d",    1, OP_FENCE,0,0, 0, 0, eD());
        add("fence_e",    1, OP_FENCE,0,0, 0, 0, eE(0,0,1,0,0,0));
        add("fence_wb",   1, OP_FENCE,0,0, 0, 0, eW(0,0,0));
        add("bad_f",      1, OP_BAD, 0, 0, 1, 0, eF(1));
        add("bad_d",      1, OP_BAD, 0, 0, 0, 0, eD());
`ifdef CTRL_FSM_ILLEGAL_TRAP_EN
        add("bad_fault",  1, OP_BAD, 0, 0, 0, 0, eX());
`else
        add("bad_e",      1, OP_BAD, 0, 0, 0, 0, eE(0,0,1,0,0,0));
        add("bad_wb",     1, OP_BAD, 0, 0, 0, 0, eW(0,0,0));
`endif
        add("to_reset",   0, OP_IMM, 0, 0, 0, 0, eZ());
        add("to_c1",      1, OP_IMM, 0, 0, 0, 0, eF(0));
        add("to_c2",      1, OP_IMM, 0, 0, 0, 0, eF(0));
        add("to_c3",      1, OP_IMM, 0, 0, 0, 0, eF(0));
        add("to_c4",      1, OP_IMM, 0, 0, 0, 0, eF(0));
        add("to_c5_fault",1, OP_IMM, 0, 0, 0, 0, eX());
        add("fault_hold", 1, OP_IMM, 0, 0, 1, 1, eX());
        add("fault_rst",  0, OP_IMM, 0, 0, 1, 0, eZ());
        add("clean_f",    1, OP_IMM, 0, 0, 1, 0, eF(1));

        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].op, vq[i].f3, vq[i].bc, vq[i].ir, vq[i].dr);
            chk_vec(vq[i].name, act, vq[i].exp);
        end

        // Return to a known FETCH before the cycle-count runs.
        step(1'b0, OP_IMM, 3'd0, 1'b0, 1'b0, 1'b0);

        run_cpi("addi",     OP_IMM,  3'd0, 1'b0, 0, 0, 4, 1);
        run_cpi("addi_fw2", OP_IMM,  3'd0, 1'b0, 2, 0, 6, 1);
        run_cpi("load_mw3", OP_LOAD, 3'd2, 1'b0, 0, 3, 8, 1);
        run_cpi("store",    OP_ST,   3'd0, 1'b0, 0, 1, 5, 0);
        run_cpi("branch",   OP_BR,   3'd0, 1'b1, 0, 0, 3, 0);
        run_cpi("jal_fw1",  OP_JAL,  3'd0, 1'b0, 1, 0, 5, 1);

        // Reset landing in the middle of a store's memory phase.
        step(1'b1, OP_ST, 3'd2, 1'b0, 1'b1, 1'b0);
        step(1'b1, OP_ST, 3'd2, 1'b0, 1'b0, 1'b0);
        step(1'b1, OP_ST, 3'd2, 1'b0, 1'b0, 1'b0);
        step(1'b1, OP_ST, 3'd2, 1'b0, 1'b0, 1'b0);
        chk_int("st_in_mem", {29'd0, state}, 3);
        step(1'b0, OP_ST, 3'd2, 1'b0, 1'b0, 1'b1);
        chk_int("st_rst_quiet", {27'd0, pc_we, retire, bus.dmem_req_o, rf_we, bus.imem_req_o}, 0);
        step(1'b1, OP_IMM, 3'd0, 1'b0, 1'b0, 1'b0);
        chk_int("st_rst_fetch", {28'd0, state, bus.imem_req_o}, 1);
        run_cpi("after_rst", OP_IMM, 3'd0, 1'b0, 0, 0, 4, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_fsm.md
CTRL_FSM -- requirements
Module: ctrl_fsm

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 16: memory wait-cycle limit before fault, range 2..255.
REQ-002 SHALL have port clk_i  input  1  sole clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n_i  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports opcode_i  input  7 (from instruction decoder), funct3_i  input  3, and branch_cond_i  input  1 (branch comparator result).
REQ-005 SHALL have ports imem_req_o  output  1, imem_ready_i  input  1 (instruction fetch handshake).
REQ-006 SHALL have ports dmem_req_o  output  1, dmem_we_o  output  1, dmem_size_o  output  2 (funct3[1:0]), dmem_ready_i  input  1.
REQ-007 SHALL have ports ir_we_o, pc_we_o, rf_we_o, alu_a_sel_o (0=rs1, 1=pc), alu_b_sel_o (0=rs2, 1=imm), each output 1.
REQ-008 SHALL have outputs pc_sel_o 2 (0=pc+4, 1=pc+imm, 2=jalr target), wb_sel_o 2 (0=alu, 1=mem, 2=pc+4, 3=imm_u), imm_sel_o 3 (0=I, 1=S, 2=B, 3=U, 4=J).
REQ-009 SHALL have outputs state_o 3, fault_o 1 (sticky) and retire_o 1 (one-cycle pulse per completed instruction).

Function
REQ-010 SHALL encode states as FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, FAULT=5, and drive state_o with the current state.
REQ-011 FETCH SHALL assert imem_req_o; when imem_ready_i=1, it SHALL pulse ir_we_o combinationally in that cycle and go to DECODE.
REQ-012 DECODE SHALL last exactly 1 cycle, latching opcode_i and funct3_i into an internal class register; all later states SHALL use only the latched values.
REQ-013 Legal opcodes SHALL be 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111 and 1110011; 0001111 and 1110011 SHALL execute as NOP.
REQ-014 EXECUTE SHALL drive the ALU and immediate selects for the latched class: AUIPC/JAL/BRANCH alu_a_sel=1; all classes except OP alu_b_sel=1.
REQ-015 EXECUTE for BRANCH SHALL assert pc_we_o and retire_o, set pc_sel_o=1 if branch_cond_i else 0, and go to FETCH.
REQ-016 EXECUTE for LOAD or STORE SHALL go to MEM; every other class SHALL go to WB.
REQ-017 MEM SHALL hold dmem_req_o=1, dmem_we_o=1 for STORE, and dmem_size_o=funct3[1:0] until dmem_ready_i=1.
REQ-018 On dmem_ready_i=1 in MEM, STORE SHALL assert pc_we_o (pc_sel_o=0) and retire_o and go to FETCH; LOAD SHALL go to WB.
REQ-019 WB SHALL assert rf_we_o for every class except NOP, with wb_sel_o = 1 for LOAD, 2 for JAL/JALR, 3 for LUI, and 0 otherwise.
REQ-020 WB SHALL assert pc_we_o and retire_o, with pc_sel_o = 1 for JAL, 2 for JALR, and 0 otherwise, then go to FETCH.
REQ-021 A wait counter SHALL clear on entry to FETCH or MEM and increment each cycle the request is held with ready=0.
REQ-022 When the wait counter reaches MAX_WAIT with ready still 0, the controller SHALL go to FAULT; ready=1 in that same cycle SHALL take priority.
REQ-023 FAULT SHALL hold fault_o=1 with all request and write-enable outputs at 0 until reset.
REQ-024 Outputs not explicitly asserted in a state SHALL be 0; each CPI SHALL be 3+fetch wait (branch), 4+wait (ALU/jump), 5+waits (load), or 4+waits (store).

Reset
REQ-025 While rst_n_i is sampled low, on the next edge the state SHALL become FETCH and the wait counter, class register and fault SHALL clear.
REQ-026 All outputs SHALL be forced to 0 combinationally while rst_n_i=0, including imem_req_o; state_o SHALL read 0.
REQ-027 Reset asserted mid-MEM or mid-FETCH SHALL abandon the transaction with no pc_we_o, rf_we_o or retire_o pulse.

Configuration
REQ-028 Macro CTRL_FSM_ILLEGAL_TRAP_EN defined: an illegal opcode in DECODE SHALL go to FAULT with fault_o=1 and no retire.
REQ-029 Macro CTRL_FSM_ILLEGAL_TRAP_EN undefined: an illegal opcode SHALL execute as NOP (EXECUTE, then WB with rf_we_o=0, pc_sel_o=0, retire_o=1).

Verification
REQ-030 ADDI (opcode 0010011), imem_ready_i=1 immediately -> states 0,1,2,4,0; rf_we_o=1 and wb_sel_o=0 in WB; retire_o pulses once; 4 cycles.
REQ-031 LOAD with dmem_ready_i delayed 3 cycles -> dmem_req_o high 4 cycles, dmem_we_o=0; WB has wb_sel_o=1; CPI 8.
REQ-032 BRANCH with branch_cond_i=1, then with 0 -> pc_sel_o=1, then 0, in EXECUTE; rf_we_o never asserted; CPI 3 each.
REQ-033 imem_ready_i held 0 with MAX_WAIT=4 -> FAULT on cycle 5 after reset release; fault_o=1 stays set until rst_n_i=0.
REQ-034 Opcode 1111111 -> FAULT with the macro defined; with it undefined, a NOP retires with rf_we_o=0.
REQ-035 rst_n_i=0 during MEM of a STORE -> state_o=0 next cycle, no pc_we_o or retire_o; a clean fetch follows release.
